// File: rtl/saturn_alu_sequencer.sv
// saturn_alu_sequencer
//   Steps a decoded ALU request across a nibble field, one nibble at a time,
//   driving the ALU prep/calc/save phase enables in turn (one cycle each).
//
// Ports
//   i_clk            rising-edge clock
//   i_reset          synchronous reset, active-low
//   i_req_valid      request present; accepted on valid & o_req_ready
//   o_req_ready      high only while idle
//   i_req_op         ALU opcode (latched on accept)
//   i_req_start      first nibble of the field (latched on accept)
//   i_req_last       last nibble of the field (latched on accept)
//   i_stall          holds the current phase and nibble, gates all enables
//   o_en_alu_prep    ALU prep-phase enable
//   o_en_alu_calc    ALU calc-phase enable
//   o_en_alu_save    ALU save-phase enable
//   o_alu_op         latched opcode
//   o_field_start    latched first nibble
//   o_field_last     latched last nibble
//   o_nibble         nibble currently being processed
//   o_done           one-cycle pulse when the sequence completes
//   o_err            one-cycle pulse when a field is rejected
//
// Configuration
//   SATURN_ALU_SEQ_WRAP_EN  when defined, start > last wraps through nibble 15
//                           to 0; otherwise such a request is rejected via ERR.

module saturn_alu_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [4:0] i_req_op,
  input  logic [3:0] i_req_start,
  input  logic [3:0] i_req_last,
  input  logic       i_stall,
  output logic       o_en_alu_prep,
  output logic       o_en_alu_calc,
  output logic       o_en_alu_save,
  output logic [4:0] o_alu_op,
  output logic [3:0] o_field_start,
  output logic [3:0] o_field_last,
  output logic [3:0] o_nibble,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StCalc = 3'd2;
  localparam logic [2:0] StSave = 3'd3;
  localparam logic [2:0] StDone = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] start_q, start_d;
  logic [3:0] last_q, last_d;
  logic [3:0] nibble_q, nibble_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    start_d  = start_q;
    last_d   = last_q;
    nibble_d = nibble_q;
    case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          op_d     = i_req_op;
          start_d  = i_req_start;
          last_d   = i_req_last;
          nibble_d = i_req_start;
`ifdef SATURN_ALU_SEQ_WRAP_EN
          state_d  = StPrep;
`else
          state_d  = (i_req_start > i_req_last) ? StErr : StPrep;
`endif
        end
      end
      StPrep: if (!i_stall) state_d = StCalc;
      StCalc: if (!i_stall) state_d = StSave;
      StSave: begin
        if (!i_stall) begin
          if (nibble_q != last_q) begin
            // 4-bit add wraps 15 -> 0 for wrapped fields.
            nibble_d = nibble_q + 4'd1;
            state_d  = StPrep;
          end else begin
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      op_q     <= 5'd0;
      start_q  <= 4'd0;
      last_q   <= 4'd0;
      nibble_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      start_q  <= start_d;
      last_q   <= last_d;
      nibble_q <= nibble_d;
    end
  end

  // Enables are gated combinationally so a stall silences the ALU in the
  // same cycle it is raised.
  assign o_req_ready   = (state_q == StIdle);
  assign o_en_alu_prep = (state_q == StPrep) && !i_stall;
  assign o_en_alu_calc = (state_q == StCalc) && !i_stall;
  assign o_en_alu_save = (state_q == StSave) && !i_stall;
  assign o_done        = (state_q == StDone);
  assign o_err         = (state_q == StErr);
  assign o_alu_op      = op_q;
  assign o_field_start = start_q;
  assign o_field_last  = last_q;
  assign o_nibble      = nibble_q;

endmodule

// File: tb/tb_saturn_alu_sequencer.sv
module tb_saturn_alu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [4:0] i_req_op;
  logic [3:0] i_req_start;
  logic [3:0] i_req_last;
  logic       i_stall;
  logic       o_en_alu_prep;
  logic       o_en_alu_calc;
  logic       o_en_alu_save;
  logic [4:0] o_alu_op;
  logic [3:0] o_field_start;
  logic [3:0] o_field_last;
  logic [3:0] o_nibble;
  logic       o_done;
  logic       o_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed control vector: {prep, calc, save, done, err, ready}
  logic [5:0] obs;
  assign obs = {o_en_alu_prep, o_en_alu_calc, o_en_alu_save, o_done, o_err, o_req_ready};

  localparam logic [5:0] VP = 6'b100000;
  localparam logic [5:0] VC = 6'b010000;
  localparam logic [5:0] VS = 6'b001000;
  localparam logic [5:0] VD = 6'b000100;
  localparam logic [5:0] VE = 6'b000010;
  localparam logic [5:0] VR = 6'b000001;
  localparam logic [5:0] VZ = 6'b000000;

  saturn_alu_sequencer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_op      (i_req_op),
    .i_req_start   (i_req_start),
    .i_req_last    (i_req_last),
    .i_stall       (i_stall),
    .o_en_alu_prep (o_en_alu_prep),
    .o_en_alu_calc (o_en_alu_calc),
    .o_en_alu_save (o_en_alu_save),
    .o_alu_op      (o_alu_op),
    .o_field_start (o_field_start),
    .o_field_last  (o_field_last),
    .o_nibble      (o_nibble),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled on the following falling edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic request(input logic [4:0] op, input logic [3:0] s, input logic [3:0] l);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_start = s;
    i_req_last  = l;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_req_valid = 1'b0; i_stall = 1'b0;
    i_req_op = 5'd0; i_req_start = 4'd0; i_req_last = 4'd0;
    tick(); tick();
    @(negedge i_clk);
    n_cmp++;
    if (obs !== VR) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected %b", obs, VR);
    end
    n_cmp++;
    if ({o_alu_op, o_field_start, o_field_last, o_nibble} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got op=%h s=%h l=%h n=%h expected all 0",
               o_alu_op, o_field_start, o_field_last, o_nibble);
    end
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  // start=3, last=3, op=4: P C S at c1..c3, done c4, ready c5
  task automatic test_single();
    logic [5:0] tbl [5];
    tbl = '{VP, VC, VS, VD, VR};
    request(5'h04, 4'd3, 4'd3);
    @(negedge i_clk);
    n_cmp++;
    if (obs !== VR) begin
      n_bad++; $display("FAIL single_c0: got %b expected %b", obs, VR);
    end
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (obs !== tbl[c-1]) begin
        n_bad++; $display("FAIL single_c%0d: got %b expected %b", c, obs, tbl[c-1]);
      end
      if (c <= 3) begin
        n_cmp++;
        if (o_nibble !== 4'd3 || o_alu_op !== 5'h04) begin
          n_bad++;
          $display("FAIL single_nib_c%0d: got nib=%0d op=%h expected nib=3 op=04",
                   c, o_nibble, o_alu_op);
        end
      end
      tick();
    end
  endtask

  // start=0, last=15: 48 enable cycles, done at c49
  task automatic test_full_field();
    int         en_cnt = 0;
    logic [5:0] exp_v;
    logic [3:0] exp_n;
    request(5'h11, 4'd0, 4'd15);
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge i_clk);
      exp_n = 4'((c - 1) / 3);
      if (c <= 48) exp_v = ((c - 1) % 3 == 0) ? VP : ((c - 1) % 3 == 1) ? VC : VS;
      else if (c == 49) exp_v = VD;
      else exp_v = VR;
      if (o_en_alu_prep || o_en_alu_calc || o_en_alu_save) en_cnt++;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL full_c%0d: got %b expected %b", c, obs, exp_v);
      end
      if (c <= 48) begin
        n_cmp++;
        if (o_nibble !== exp_n) begin
          n_bad++; $display("FAIL full_nib_c%0d: got %0d expected %0d", c, o_nibble, exp_n);
        end
      end
      tick();
    end
    n_cmp++;
    if (en_cnt != 48) begin
      n_bad++; $display("FAIL full_en_count: got %0d expected 48", en_cnt);
    end
  endtask

  // start=0, last=2, stall during nibble-1 CALC at c5-c6
  task automatic test_stall();
    logic [5:0] tbl [13];
    tbl = '{VP, VC, VS, VP, VZ, VZ, VC, VS, VP, VC, VS, VD, VR};
    request(5'h07, 4'd0, 4'd2);
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      i_stall = (c == 5 || c == 6);
      @(negedge i_clk);
      n_cmp++;
      if (obs !== tbl[c-1]) begin
        n_bad++; $display("FAIL stall_c%0d: got %b expected %b", c, obs, tbl[c-1]);
      end
      if (c == 5 || c == 6 || c == 7) begin
        n_cmp++;
        if (o_nibble !== 4'd1) begin
          n_bad++; $display("FAIL stall_nib_c%0d: got %0d expected 1", c, o_nibble);
        end
      end
      tick();
    end
    i_stall = 1'b0;
  endtask

  // start=14, last=1: wraps with the macro, rejected without it
  task automatic test_wrap();
`ifdef SATURN_ALU_SEQ_WRAP_EN
    logic [3:0] nibs [4];
    logic [5:0] exp_v;
    nibs = '{4'd14, 4'd15, 4'd0, 4'd1};
    request(5'h02, 4'd14, 4'd1);
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge i_clk);
      if (c <= 12) exp_v = ((c - 1) % 3 == 0) ? VP : ((c - 1) % 3 == 1) ? VC : VS;
      else if (c == 13) exp_v = VD;
      else exp_v = VR;
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL wrap_c%0d: got %b expected %b", c, obs, exp_v);
      end
      if (c <= 12) begin
        n_cmp++;
        if (o_nibble !== nibs[(c-1)/3]) begin
          n_bad++;
          $display("FAIL wrap_nib_c%0d: got %0d expected %0d", c, o_nibble, nibs[(c-1)/3]);
        end
      end
      tick();
    end
`else
    logic [5:0] tbl [2];
    tbl = '{VE, VR};
    request(5'h02, 4'd14, 4'd1);
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (obs !== tbl[c-1]) begin
        n_bad++; $display("FAIL err_c%0d: got %b expected %b", c, obs, tbl[c-1]);
      end
      tick();
    end
`endif
  endtask

  // Reset asserted during nibble-0 SAVE (c3) of start=0, last=7
  task automatic test_reset_mid();
    logic [5:0] tbl [3];
    tbl = '{VP, VC, VS};
    request(5'h1f, 4'd0, 4'd7);
    tick();
    i_req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) i_reset = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if (obs !== tbl[c-1]) begin
        n_bad++; $display("FAIL rstmid_c%0d: got %b expected %b", c, obs, tbl[c-1]);
      end
      tick();
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (obs !== VR || {o_alu_op, o_field_start, o_field_last, o_nibble} !== 17'd0) begin
      n_bad++;
      $display("FAIL rstmid_after: got ctrl=%b op=%h s=%h l=%h n=%h expected ctrl=%b regs 0",
               obs, o_alu_op, o_field_start, o_field_last, o_nibble, VR);
    end
    tick();
    for (int c = 5; c <= 12; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (obs !== VR) begin
        n_bad++; $display("FAIL rstmid_idle_c%0d: got %b expected %b", c, obs, VR);
      end
      tick();
    end
  endtask

  // valid held high with new values while busy; next accept only at c8
  task automatic test_back_to_back();
    logic [5:0] tbl [13];
    logic [3:0] nib;
    tbl = '{VP, VC, VS, VP, VC, VS, VD, VR, VP, VC, VS, VD, VR};
    request(5'h0a, 4'd2, 4'd3);
    tick();
    request(5'h15, 4'd5, 4'd5);
    for (int c = 1; c <= 13; c++) begin
      if (c == 9) i_req_valid = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if (obs !== tbl[c-1]) begin
        n_bad++; $display("FAIL b2b_c%0d: got %b expected %b", c, obs, tbl[c-1]);
      end
      if (c <= 7) begin
        nib = (c <= 3) ? 4'd2 : 4'd3;
        n_cmp++;
        if ({o_alu_op, o_field_start, o_field_last, o_nibble} !== {5'h0a, 4'd2, 4'd3, nib}) begin
          n_bad++;
          $display("FAIL b2b_latch_c%0d: got op=%h s=%0d l=%0d n=%0d expected op=0a s=2 l=3 n=%0d",
                   c, o_alu_op, o_field_start, o_field_last, o_nibble, nib);
        end
      end else if (c >= 9 && c <= 11) begin
        n_cmp++;
        if ({o_alu_op, o_field_start, o_field_last, o_nibble} !== {5'h15, 4'd5, 4'd5, 4'd5}) begin
          n_bad++;
          $display("FAIL b2b_new_c%0d: got op=%h s=%0d l=%0d n=%0d expected op=15 s=5 l=5 n=5",
                   c, o_alu_op, o_field_start, o_field_last, o_nibble);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_field();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/saturn_alu_sequencer.md
SATURN_ALU_SEQUENCER -- requirements
Module: saturn_alu_sequencer

Interface
REQ-001 The block SHALL have clock i_clk and reset i_reset, synchronous, active-low, as its first two ports.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_reset  input  1  synchronous reset, active-low.
REQ-004 i_req_valid  input  1  decoded ALU request present.
REQ-005 o_req_ready  output  1  sequencer idle; a request is accepted on valid&ready.
REQ-006 i_req_op  input  5  ALU opcode.
REQ-007 i_req_start  input  4  first nibble of the field.
REQ-008 i_req_last  input  4  last nibble of the field.
REQ-009 i_stall  input  1  freezes the sequence in place.
REQ-010 o_en_alu_prep, o_en_alu_calc, o_en_alu_save  output  1 each  ALU phase enables, fed to the ALU i_en_alu_* ports.
REQ-011 o_alu_op  output  5  latched opcode.
REQ-012 o_field_start, o_field_last  output  4 each  latched field bounds.
REQ-013 o_nibble  output  4  nibble currently being processed.
REQ-014 o_done  output  1  one-cycle pulse at sequence completion.
REQ-015 o_err  output  1  one-cycle pulse for a rejected field.

Function
REQ-016 FSM states SHALL be IDLE, PREP, CALC, SAVE, DONE, ERR.
- o_req_ready = 1 only in IDLE.
REQ-017 Accept (valid&ready in IDLE) SHALL latch the op, start and last values, set o_nibble=start and go to PREP.
- o_en_alu_prep is high the cycle after acceptance.
REQ-018 Per nibble the sequence SHALL be PREP -> CALC -> SAVE, one cycle each, with only the matching enable high.
REQ-019 From SAVE, if o_nibble != last: o_nibble increments mod 16 and the state goes to PREP; else the state goes to DONE.
REQ-020 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE.
- The minimum request-to-request interval is 3*n+2 cycles.
REQ-021 Nibble count n = ((last - start) mod 16) + 1, range 1..16.
- start=0, last=15 gives n=16.
REQ-022 i_stall=1 in PREP/CALC/SAVE SHALL hold the state and o_nibble, and force all three enables low.
- Stall SHALL be ignored in IDLE, DONE and ERR.
REQ-023 i_req_valid outside IDLE SHALL be ignored with no side effects.
REQ-024 At most one of prep/calc/save/done/err SHALL be high in any cycle.

Reset
REQ-025 While i_reset=0 at a clock edge, the block SHALL enter IDLE.
- Enables, o_done, o_err, o_nibble, o_alu_op, o_field_start and o_field_last are cleared to 0; o_req_ready=1.
REQ-026 Reset mid-sequence SHALL abort without a o_done pulse.
- No enable is asserted in the cycle after the reset edge.

Configuration
REQ-027 Macro SATURN_ALU_SEQ_WRAP_EN SHALL control fields with start>last.
REQ-028 With SATURN_ALU_SEQ_WRAP_EN defined, start>last SHALL wrap through nibble 15 to 0 per REQ-021.
REQ-029 Without the macro, an accepted request with start>last SHALL go to ERR for one cycle.
- o_err=1 in that cycle, no enables are asserted, then the state returns to IDLE.
- start<=last behaves identically in both builds.

Verification
REQ-030 start=3, last=3, op=5'h04 accepted at cycle 0.
- Response: prep at c1, calc at c2, save at c3, with o_nibble=3 throughout; o_done at c4; ready at c5.
REQ-031 start=0, last=15.
- Response: 48 enable cycles, o_nibble stepping 0..15; o_done at c49.
REQ-032 start=0, last=2, with i_stall high for 2 cycles at nibble 1 CALC (c5-c6).
- Response: calc at c7, enables low at c5-c6; o_done at c12.
REQ-033 start=14, last=1.
- With the macro: nibbles 14, 15, 0, 1; o_done at c13.
- Without the macro: o_err at c1, no enables, ready at c2.
REQ-034 i_reset=0 during nibble-0 SAVE of start=0, last=7.
- Response: next cycle all outputs 0, ready=1, o_done never pulses.
REQ-035 i_req_valid held high with new values during CALC.
- Response: the latched op/start/last values are unchanged; the new request is accepted only after DONE->IDLE.
